// File: rtl/sobel_pkg.sv
// Shared types and constants for the Sobel frame sequencer.
package sobel_pkg;

  // Smallest image side that still yields one 3x3 window.
  localparam int MIN_DIM  = 3;
  // Rows (and columns) covered by the window buffer.
  localparam int WIN_ROWS = 3;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_CHECK     = 4'd1,
    ST_ERROR     = 4'd2,
    ST_RD_REQ    = 4'd3,
    ST_RD_WAIT   = 4'd4,
    ST_LOAD      = 4'd5,
    ST_SHIFT     = 4'd6,
    ST_GRAD      = 4'd7,
    ST_GRAD_WAIT = 4'd8,
    ST_WR_REQ    = 4'd9,
    ST_WR_WAIT   = 4'd10,
    ST_ADVANCE   = 4'd11,
    ST_DONE      = 4'd12
  } seq_state_t;

endpackage

// File: rtl/sobel_addr_gen.sv
// Raster counters and address generation for the Sobel sequencer.
// Row bases are kept as running sums (+W per row) so no multiplier is needed.
// The read column counter runs ahead by one after the last read of a window,
// which is exactly the column the next shifted window has to fetch.
module sobel_addr_gen
  import sobel_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DIM_W  = 12
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              init,
  input  logic              rd_step,
  input  logic              adv,
  input  logic [DIM_W-1:0]  width,
  input  logic [DIM_W-1:0]  length,
  input  logic [ADDR_W-1:0] base_r,
  input  logic [ADDR_W-1:0] base_w,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              last_read,
  output logic              last_col,
  output logic              last_row
);

  logic [DIM_W-1:0]  r_q, r_d, c_q, c_d, col_q, col_d;
  logic [1:0]        k_q, k_d;
  logic [ADDR_W-1:0] row_base_q, row_base_d, rd_row_q, rd_row_d, wr_base_q, wr_base_d;
  logic [ADDR_W-1:0] w_ext, wm2_ext;

  assign w_ext   = ADDR_W'(width);
  assign wm2_ext = ADDR_W'(width - DIM_W'(2));

  assign last_read = (k_q == 2'(WIN_ROWS - 1)) && (col_q == c_q + DIM_W'(2));
  assign last_col  = (c_q == width - DIM_W'(MIN_DIM));
  assign last_row  = (r_q == length - DIM_W'(MIN_DIM));
  assign rd_addr   = rd_row_q + ADDR_W'(col_q);
  assign wr_addr   = wr_base_q + ADDR_W'(c_q);

  // Next-value logic: frame init, per-read step (top-down, then next column), window advance.
  always_comb begin
    r_d        = r_q;
    c_d        = c_q;
    col_d      = col_q;
    k_d        = k_q;
    row_base_d = row_base_q;
    rd_row_d   = rd_row_q;
    wr_base_d  = wr_base_q;
    if (init) begin
      r_d        = '0;
      c_d        = '0;
      col_d      = '0;
      k_d        = '0;
      row_base_d = base_r;
      rd_row_d   = base_r;
      wr_base_d  = base_w;
    end else if (rd_step) begin
      if (k_q == 2'(WIN_ROWS - 1)) begin
        k_d      = '0;
        rd_row_d = row_base_q;
        col_d    = col_q + DIM_W'(1);
      end else begin
        k_d      = k_q + 2'd1;
        rd_row_d = rd_row_q + w_ext;
      end
    end else if (adv) begin
      if (last_col) begin
        c_d        = '0;
        col_d      = '0;
        k_d        = '0;
        r_d        = r_q + DIM_W'(1);
        row_base_d = row_base_q + w_ext;
        rd_row_d   = row_base_q + w_ext;
        wr_base_d  = wr_base_q + wm2_ext;
      end else begin
        c_d = c_q + DIM_W'(1);
      end
    end
  end

  // Counter and accumulator registers.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      r_q        <= '0;
      c_q        <= '0;
      col_q      <= '0;
      k_q        <= '0;
      row_base_q <= '0;
      rd_row_q   <= '0;
      wr_base_q  <= '0;
    end else begin
      r_q        <= r_d;
      c_q        <= c_d;
      col_q      <= col_d;
      k_q        <= k_d;
      row_base_q <= row_base_d;
      rd_row_q   <= rd_row_d;
      wr_base_q  <= wr_base_d;
    end
  end

endmodule

// File: rtl/sobel_frame_sequencer.sv
// Raster-scan sequencer: reads 3x3 windows over the bus, drives the window
// buffer and gradient unit, and writes each gradient pixel back.
// Bus handshake: mem_req is the valid; it rises with mem_addr/mem_write/mem_wdata
// already stable and holds them until mem_ack (the ready) is sampled high while
// mem_req is high. That cycle completes the transfer; ack with mem_req low is ignored.
module sobel_frame_sequencer
  import sobel_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DIM_W  = 12
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              start,
  input  logic [DIM_W-1:0]  width,
  input  logic [DIM_W-1:0]  length,
  input  logic [ADDR_W-1:0] base_addr_r,
  input  logic [ADDR_W-1:0] base_addr_w,
  output logic              mem_req,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic              mem_ack,
  input  logic [7:0]        mem_rdata,
  output logic              win_load,
  output logic [7:0]        win_pixel,
  output logic              win_shift,
  output logic              grad_start,
  input  logic              grad_done,
  input  logic [7:0]        grad_value,
  output logic              busy,
  output logic              frame_done,
  output logic              cfg_error,
  output seq_state_t        dbg_state
);

  seq_state_t        state_q, state_d;
  logic              mem_req_q, mem_req_d, mem_write_q, mem_write_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [7:0]        mem_wdata_q, mem_wdata_d, win_pixel_q, win_pixel_d;
  logic              win_load_q, win_load_d, win_shift_q, win_shift_d;
  logic              grad_start_q, grad_start_d, busy_q, busy_d;
  logic              frame_done_q, frame_done_d, cfg_error_q, cfg_error_d;
  logic [DIM_W-1:0]  width_q, width_d, length_q, length_d;
  logic [ADDR_W-1:0] base_r_q, base_r_d, base_w_q, base_w_d;
  logic              ag_init, ag_rd_step, ag_adv;
  logic [ADDR_W-1:0] ag_rd_addr, ag_wr_addr;
  logic              ag_last_read, ag_last_col, ag_last_row;

  sobel_addr_gen #(.ADDR_W(ADDR_W), .DIM_W(DIM_W)) u_addr_gen (
    .clk       (clk),
    .n_rst     (n_rst),
    .init      (ag_init),
    .rd_step   (ag_rd_step),
    .adv       (ag_adv),
    .width     (width_q),
    .length    (length_q),
    .base_r    (base_r_q),
    .base_w    (base_w_q),
    .rd_addr   (ag_rd_addr),
    .wr_addr   (ag_wr_addr),
    .last_read (ag_last_read),
    .last_col  (ag_last_col),
    .last_row  (ag_last_row)
  );

  // Sequencer next-state and registered-output logic; pulses default low.
  always_comb begin
    state_d      = state_q;
    mem_req_d    = mem_req_q;
    mem_write_d  = mem_write_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    win_pixel_d  = win_pixel_q;
    busy_d       = busy_q;
    width_d      = width_q;
    length_d     = length_q;
    base_r_d     = base_r_q;
    base_w_d     = base_w_q;
    win_load_d   = 1'b0;
    win_shift_d  = 1'b0;
    grad_start_d = 1'b0;
    frame_done_d = 1'b0;
    cfg_error_d  = 1'b0;
    ag_init      = 1'b0;
    ag_rd_step   = 1'b0;
    ag_adv       = 1'b0;
    case (state_q)
      ST_IDLE: if (start) begin
        width_d  = width;
        length_d = length;
        base_r_d = base_addr_r;
        base_w_d = base_addr_w;
        busy_d   = 1'b1;
        state_d  = ST_CHECK;
      end
      ST_CHECK: begin
        if ((width_q < DIM_W'(MIN_DIM)) || (length_q < DIM_W'(MIN_DIM))) begin
          cfg_error_d = 1'b1;
          busy_d      = 1'b0;
          state_d     = ST_ERROR;
        end else begin
          ag_init = 1'b1;
          state_d = ST_RD_REQ;
        end
      end
      ST_RD_REQ: begin
        mem_req_d   = 1'b1;
        mem_write_d = 1'b0;
        mem_addr_d  = ag_rd_addr;
        state_d     = ST_RD_WAIT;
      end
      ST_RD_WAIT: if (mem_ack) begin
        mem_req_d   = 1'b0;
        win_load_d  = 1'b1;
        win_pixel_d = mem_rdata;
        state_d     = ST_LOAD;
      end
      ST_LOAD: begin
        ag_rd_step = 1'b1;
        if (ag_last_read) begin
          grad_start_d = 1'b1;
          state_d      = ST_GRAD;
        end else begin
          state_d = ST_RD_REQ;
        end
      end
      ST_SHIFT:     state_d = ST_RD_REQ;
      ST_GRAD:      state_d = ST_GRAD_WAIT;
      ST_GRAD_WAIT: if (grad_done) begin
        mem_wdata_d = grad_value;
        state_d     = ST_WR_REQ;
      end
      ST_WR_REQ: begin
        mem_req_d   = 1'b1;
        mem_write_d = 1'b1;
        mem_addr_d  = ag_wr_addr;
        state_d     = ST_WR_WAIT;
      end
      ST_WR_WAIT: if (mem_ack) begin
        mem_req_d   = 1'b0;
        mem_write_d = 1'b0;
        state_d     = ST_ADVANCE;
      end
      ST_ADVANCE: begin
        if (ag_last_col && ag_last_row) begin
          frame_done_d = 1'b1;
          busy_d       = 1'b0;
          state_d      = ST_DONE;
        end else begin
          ag_adv = 1'b1;
          if (ag_last_col) begin
            state_d = ST_RD_REQ;
          end else begin
            win_shift_d = 1'b1;
            state_d     = ST_SHIFT;
          end
        end
      end
      ST_DONE, ST_ERROR: state_d = ST_IDLE;
      default:           state_d = ST_IDLE;
    endcase
  end

  // State, handshake outputs and configuration latches.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q      <= ST_IDLE;
      mem_req_q    <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      win_pixel_q  <= '0;
      win_load_q   <= 1'b0;
      win_shift_q  <= 1'b0;
      grad_start_q <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      cfg_error_q  <= 1'b0;
      width_q      <= '0;
      length_q     <= '0;
      base_r_q     <= '0;
      base_w_q     <= '0;
    end else begin
      state_q      <= state_d;
      mem_req_q    <= mem_req_d;
      mem_write_q  <= mem_write_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      win_pixel_q  <= win_pixel_d;
      win_load_q   <= win_load_d;
      win_shift_q  <= win_shift_d;
      grad_start_q <= grad_start_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      cfg_error_q  <= cfg_error_d;
      width_q      <= width_d;
      length_q     <= length_d;
      base_r_q     <= base_r_d;
      base_w_q     <= base_w_d;
    end
  end

  assign mem_req    = mem_req_q;
  assign mem_write  = mem_write_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign win_load   = win_load_q;
  assign win_pixel  = win_pixel_q;
  assign win_shift  = win_shift_q;
  assign grad_start = grad_start_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;
  assign cfg_error  = cfg_error_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_sobel_frame_sequencer.sv
// Bench for sobel_frame_sequencer: memory and gradient stubs, an image-level
// reference model (expected reads, pixels and writes per frame) and a report.
module tb_sobel_frame_sequencer;

  localparam int ADDR_W = 32;
  localparam int DIM_W  = 12;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic n_rst = 1'b0;
  always #5 clk = ~clk;

  logic              start = 1'b0;
  logic [DIM_W-1:0]  width = '0, length = '0;
  logic [ADDR_W-1:0] base_addr_r = '0, base_addr_w = '0;
  logic              mem_req, mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic              mem_ack = 1'b0;
  logic [7:0]        mem_rdata = '0;
  logic              win_load, win_shift, grad_start;
  logic [7:0]        win_pixel;
  logic              grad_done = 1'b0;
  logic [7:0]        grad_value = '0;
  logic              busy, frame_done, cfg_error;
  logic [3:0]        dbg_state;

  sobel_frame_sequencer #(.ADDR_W(ADDR_W), .DIM_W(DIM_W)) dut (
    .clk(clk), .n_rst(n_rst), .start(start), .width(width), .length(length),
    .base_addr_r(base_addr_r), .base_addr_w(base_addr_w),
    .mem_req(mem_req), .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .win_load(win_load), .win_pixel(win_pixel), .win_shift(win_shift),
    .grad_start(grad_start), .grad_done(grad_done), .grad_value(grad_value),
    .busy(busy), .frame_done(frame_done), .cfg_error(cfg_error), .dbg_state(dbg_state)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [ADDR_W-1:0] exp_rd_q[$];
  logic [ADDR_W-1:0] exp_wr_q[$];
  logic [7:0]        exp_wd_q[$];
  logic [7:0]        exp_pix_q[$];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] pix_of(input logic [ADDR_W-1:0] a);
    return a[7:0] ^ a[15:8] ^ 8'hA5;
  endfunction

  // Image-level model: every window (r,c), c==0 reloads 9 pixels column-major,
  // otherwise only the new right-hand column; one write per window.
  task automatic build_model(input int w, input int l, input logic [ADDR_W-1:0] br,
                             input logic [ADDR_W-1:0] bw);
    logic [ADDR_W-1:0] a;
    exp_rd_q.delete(); exp_wr_q.delete(); exp_wd_q.delete(); exp_pix_q.delete();
    if (w < 3 || l < 3) return;
    for (int r = 0; r < l - 2; r++) begin
      for (int c = 0; c < w - 2; c++) begin
        for (int j = 0; j < 3; j++) begin
          if (c == 0 || j == 2) begin
            for (int k = 0; k < 3; k++) begin
              a = br + ADDR_W'((r + k) * w + c + j);
              exp_rd_q.push_back(a);
              exp_pix_q.push_back(pix_of(a));
            end
          end
        end
        exp_wr_q.push_back(bw + ADDR_W'(r * (w - 2) + c));
        exp_wd_q.push_back(8'(r * 16 + c));
      end
    end
  endtask

  // ---------------- memory responder ----------------
  int loads, shifts, grads, dones, errs, rd_acks, req_cycles;
  int cur_w = 3;
  int delay_min = 0, delay_max = 0, cur_delay = 0, wait_cnt = 0;
  bit spur_en = 1'b0;
  logic [ADDR_W-1:0] first_addr = '0;
  logic first_wr = 1'b0;

  always @(negedge clk) begin
    if (!n_rst) begin
      mem_ack  = 1'b0;
      wait_cnt = 0;
    end else if (mem_ack) begin
      mem_ack = 1'b0;
    end else if (mem_req) begin
      req_cycles++;
      if (wait_cnt == 0) begin
        first_addr = mem_addr;
        first_wr   = mem_write;
      end else begin
        check_eq("addr_stable", mem_addr, first_addr);
        check_eq("write_stable", mem_write, first_wr);
      end
      if (wait_cnt >= cur_delay) begin
        mem_ack = 1'b1;
        if (mem_write) begin
          check_eq("wr_pending", exp_wr_q.size() != 0, 1);
          if (exp_wr_q.size() != 0) begin
            check_eq("wr_addr", mem_addr, exp_wr_q.pop_front());
            check_eq("wr_data", mem_wdata, exp_wd_q.pop_front());
          end
        end else begin
          mem_rdata = pix_of(mem_addr);
          rd_acks++;
          check_eq("rd_pending", exp_rd_q.size() != 0, 1);
          if (exp_rd_q.size() != 0) check_eq("rd_addr", mem_addr, exp_rd_q.pop_front());
        end
        wait_cnt  = 0;
        cur_delay = $urandom_range(delay_min, delay_max);
      end else begin
        wait_cnt++;
      end
    end else if (spur_en && $urandom_range(0, 3) == 0) begin
      mem_ack   = 1'b1;
      mem_rdata = 8'($urandom);
    end
  end

  // ---------------- window / gradient monitor and stub ----------------
  bit gpend = 1'b0, prev_load = 1'b0;
  int gcnt = 0, gdelay = 1;

  always @(negedge clk) begin
    if (!n_rst) begin
      gpend     = 1'b0;
      grad_done = 1'b0;
      prev_load = 1'b0;
    end else begin
      if (win_load) begin
        loads++;
        check_eq("pix_pending", exp_pix_q.size() != 0, 1);
        if (exp_pix_q.size() != 0) check_eq("win_pixel", win_pixel, exp_pix_q.pop_front());
      end
      if (win_shift) shifts++;
      if (frame_done) begin
        dones++;
        check_eq("busy_at_done", busy, 0);
      end
      if (cfg_error) errs++;
      if (grad_done) begin
        grad_done = 1'b0;
      end else if (gpend) begin
        if (gcnt >= gdelay) begin
          grad_done  = 1'b1;
          grad_value = 8'(((grads - 1) / (cur_w - 2)) * 16 + ((grads - 1) % (cur_w - 2)));
          gpend      = 1'b0;
        end else begin
          gcnt++;
        end
      end
      if (grad_start) begin
        grads++;
        check_eq("grad_after_load", prev_load, 1);
        gpend  = 1'b1;
        gcnt   = 1;
        gdelay = $urandom_range(1, 3);
      end
      prev_load = win_load;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic clear_counts();
    loads = 0; shifts = 0; grads = 0; dones = 0; errs = 0; rd_acks = 0; req_cycles = 0;
  endtask

  task automatic kick(input int w, input int l, input logic [ADDR_W-1:0] br,
                      input logic [ADDR_W-1:0] bw, input string tag);
    @(negedge clk);
    width = DIM_W'(w); length = DIM_W'(l); base_addr_r = br; base_addr_w = bw; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_eq({tag, " busy_after_start"}, busy, 1);
    // Scramble inputs: only the values present at the accepted start matter.
    width = DIM_W'($urandom); length = DIM_W'($urandom);
    base_addr_r = $urandom; base_addr_w = $urandom;
  endtask

  task automatic run_frame(input int w, input int l, input logic [ADDR_W-1:0] br,
                           input logic [ADDR_W-1:0] bw, input int dmin, input int dmax,
                           input bit spur, input bit poke_mid, input string tag);
    bit bad;
    int exp_frames;
    bad = (w < 3) || (l < 3);
    exp_frames = bad ? 0 : (l - 2) * (w - 2);
    build_model(w, l, br, bw);
    clear_counts();
    cur_w = w; delay_min = dmin; delay_max = dmax; spur_en = spur;
    cur_delay = $urandom_range(dmin, dmax);
    kick(w, l, br, bw, tag);
    for (int cyc = 0; cyc < 20000; cyc++) begin
      if (dones != 0 || errs != 0) break;
      start = (poke_mid && cyc == 20);
      @(negedge clk); #1;
    end
    start = 1'b0;
    check_eq({tag, " ended"}, (dones + errs) != 0, 1);
    check_eq({tag, " frame_done_cnt"}, dones, bad ? 0 : 1);
    check_eq({tag, " cfg_error_cnt"}, errs, bad ? 1 : 0);
    check_eq({tag, " win_load_cnt"}, loads, bad ? 0 : (l - 2) * (9 + 3 * (w - 3)));
    check_eq({tag, " win_shift_cnt"}, shifts, bad ? 0 : (l - 2) * (w - 3));
    check_eq({tag, " grad_cnt"}, grads, exp_frames);
    check_eq({tag, " rd_left"}, exp_rd_q.size(), 0);
    check_eq({tag, " wr_left"}, exp_wr_q.size(), 0);
    check_eq({tag, " busy_end"}, busy, 0);
    if (bad) begin
      check_eq({tag, " no_bus"}, req_cycles, 0);
      @(negedge clk); #1;
      check_eq({tag, " cfg_error_1cyc"}, cfg_error, 0);
      check_eq({tag, " busy_low"}, busy, 0);
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    clear_counts();
    repeat (3) @(negedge clk);
    check_eq("rst mem_req", mem_req, 0);
    check_eq("rst busy", busy, 0);
    check_eq("rst mem_addr", mem_addr, 0);
    check_eq("rst frame_done", frame_done, 0);
    check_eq("rst cfg_error", cfg_error, 0);
    check_eq("rst state", dbg_state, 0);
    n_rst = 1'b1;

    run_frame(3, 3, 32'h100, 32'h200, 0, 0, 1'b0, 1'b0, "w3l3");
    run_frame(4, 4, 32'h1000, 32'h200, 0, 0, 1'b0, 1'b0, "w4l4");
    run_frame(2, 5, 32'h100, 32'h200, 0, 0, 1'b0, 1'b0, "err_w2");
    run_frame(5, 2, 32'h100, 32'h200, 0, 0, 1'b0, 1'b0, "err_l2");
    run_frame(3, 3, 32'h100, 32'h200, 0, 5, 1'b1, 1'b0, "w3l3_slow");

    // Reset while the fifth read of a 4x4 frame is outstanding.
    build_model(4, 4, 32'h300, 32'h400);
    clear_counts();
    cur_w = 4; delay_min = 2; delay_max = 4; spur_en = 1'b0; cur_delay = 2;
    kick(4, 4, 32'h300, 32'h400, "rst_mid");
    for (int cyc = 0; cyc < 2000; cyc++) begin
      if (rd_acks == 4 && mem_req) break;
      @(negedge clk); #1;
    end
    check_eq("rst_mid reached_5th_read", rd_acks == 4 && mem_req, 1);
    n_rst = 1'b0;
    @(negedge clk); #1;
    check_eq("rst_mid mem_req", mem_req, 0);
    check_eq("rst_mid mem_write", mem_write, 0);
    check_eq("rst_mid mem_addr", mem_addr, 0);
    check_eq("rst_mid busy", busy, 0);
    check_eq("rst_mid win_load", win_load, 0);
    check_eq("rst_mid win_pixel", win_pixel, 0);
    check_eq("rst_mid pulses", {win_shift, grad_start, frame_done, cfg_error}, 0);
    n_rst = 1'b1;
    run_frame(4, 4, 32'h300, 32'h400, 0, 2, 1'b0, 1'b0, "after_rst");

    // Start mid-frame ignored; start during the frame_done cycle ignored.
    run_frame(5, 4, 32'h2000, 32'h3000, 0, 2, 1'b0, 1'b1, "mid_start");
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check_eq("start_at_done busy", busy, 0);
    check_eq("start_at_done mem_req", mem_req, 0);

    // Back-to-back frames: each start lands one cycle after the previous frame_done.
    run_frame(3, 4, 32'h10, 32'h80, 0, 1, 1'b0, 1'b0, "chain_a");
    run_frame(6, 3, 32'hFFFF_FFF8, 32'hFFFF_FFFE, 0, 1, 1'b1, 1'b0, "chain_wrap");
    for (int i = 0; i < 6; i++) begin
      run_frame($urandom_range(3, 7), $urandom_range(3, 6), $urandom, $urandom,
                0, $urandom_range(0, 3), 1'(($urandom_range(0, 1))), 1'b0, "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
